// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI-PWM register bank: address map, default
// write-lock window and the write arbiter's state types.
package spi_pwm_pkg;

    localparam int ADDR_ID           = 0;
    localparam int ADDR_PWM_CTRL     = 1;
    localparam int ADDR_CYCLES_HIGH0 = 2;
    localparam int ADDR_CYCLES_HIGH1 = 3;
    localparam int ADDR_FREQ0        = 4;
    localparam int ADDR_FREQ1        = 5;
    localparam int ADDR_IODIR        = 6;
    localparam int ADDR_IOVALUE      = 7;

    // Timing registers cannot change under a running PWM generator
    localparam int LOCK_LO_DEFAULT = ADDR_CYCLES_HIGH0;
    localparam int LOCK_HI_DEFAULT = ADDR_FREQ1;

    typedef enum logic {
        ARB_IDLE,
        ARB_SERVE
    } arb_state_t;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

endpackage

// File: rtl/spi_reg_arbiter_if.sv
// Write-request bus between the two SPI front-ends, the arbiter and the
// register bank; the arbiter uses the slave modport.
interface spi_reg_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              a_ack;
    logic              a_err;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              b_ack;
    logic              b_err;

    logic              pwm_active;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, pwm_active,
        output a_ready, a_ack, a_err, b_ready, b_ack, b_err,
        output wr_en, wr_addr, wr_data
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, pwm_active,
        input  a_ready, a_ack, a_err, b_ready, b_ack, b_err,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/spi_reg_arbiter_req_slot.sv
// One-entry write buffer for a single requester: captures on valid && ready,
// holds until granted. ready comes straight from the full flag (no bypass).
module req_slot #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              grant,
    output logic              ready,
    output logic              full,
    output logic [ADDR_W-1:0] addr_q,
    output logic [DATA_W-1:0] data_q
);

    logic              full_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;

    // grant only arrives while full and capture only while empty, so they never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (grant) begin
            full_reg <= 1'b0;
        end else if (valid && !full_reg) begin
            full_reg <= 1'b1;
            addr_reg <= addr;
            data_reg <= data;
        end
    end

    assign ready  = !full_reg;
    assign full   = full_reg;
    assign addr_q = addr_reg;
    assign data_q = data_reg;

endmodule

// File: rtl/spi_reg_arbiter.sv
// Round-robin write arbiter for the shared SPI-PWM register bank with
// ID-register and PWM-running write protection.
module spi_reg_arbiter
    import spi_pwm_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int LOCK_LO = LOCK_LO_DEFAULT,
    parameter int LOCK_HI = LOCK_HI_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_reg_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(ADDR_ID);
    localparam logic [ADDR_W-1:0] LO_ADDR = ADDR_W'(LOCK_LO);
    localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(LOCK_HI);

    // Index 0 is requester A, index 1 is requester B
    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [1:0]        slot_ready;
    logic [1:0]        slot_full;
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];
    logic [1:0]        grant;

    arb_state_t        state_reg;
    grant_t            last_grant_reg;

    logic              serve;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              locked;
    logic              reject;
    logic              commit;
    logic              pending_next;

    assign req_valid   = {bus.b_valid, bus.a_valid};
    assign req_addr[0] = bus.a_addr;
    assign req_addr[1] = bus.b_addr;
    assign req_data[0] = bus.a_data;
    assign req_data[1] = bus.b_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            req_slot #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .valid  (req_valid[gi]),
                .addr   (req_addr[gi]),
                .data   (req_data[gi]),
                .grant  (grant[gi]),
                .ready  (slot_ready[gi]),
                .full   (slot_full[gi]),
                .addr_q (slot_addr[gi]),
                .data_q (slot_data[gi])
            );
        end
    endgenerate

    // On a tie the requester not served last wins; last_grant resets to B
    assign serve    = (state_reg == ARB_SERVE);
    assign grant[0] = serve && slot_full[0] && (!slot_full[1] || last_grant_reg == GRANT_B);
    assign grant[1] = serve && slot_full[1] && !grant[0];

    assign sel_addr = grant[1] ? slot_addr[1] : slot_addr[0];
    assign sel_data = grant[1] ? slot_data[1] : slot_data[0];

    // pwm_active is looked at in the selection cycle, not when the write was buffered
    assign locked = bus.pwm_active && (sel_addr >= LO_ADDR) && (sel_addr <= HI_ADDR);
    assign reject = (sel_addr == ID_ADDR) || locked;
    assign commit = (|grant) && !reject;

    assign bus.wr_en   = commit;
    assign bus.wr_addr = commit ? sel_addr : '0;
    assign bus.wr_data = commit ? sel_data : '0;

    assign bus.a_ack   = grant[0] && !reject;
    assign bus.a_err   = grant[0] && reject;
    assign bus.b_ack   = grant[1] && !reject;
    assign bus.b_err   = grant[1] && reject;
    assign bus.a_ready = slot_ready[0];
    assign bus.b_ready = slot_ready[1];

    assign pending_next = |((slot_full & ~grant) | (req_valid & slot_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            last_grant_reg <= GRANT_B;
        end else begin
            case (state_reg)
                ARB_IDLE:  if (pending_next)  state_reg <= ARB_SERVE;
                ARB_SERVE: if (!pending_next) state_reg <= ARB_IDLE;
                default:   state_reg <= ARB_IDLE;
            endcase
            if (|grant) begin
                last_grant_reg <= grant[1] ? GRANT_B : GRANT_A;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter: single writes, contention ordering,
// write-protect rules and asynchronous reset behaviour.
module tb_spi_reg_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_reg_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    spi_reg_arbiter #(
        .ADDR_W  (3),
        .DATA_W  (8),
        .LOCK_LO (2),
        .LOCK_HI (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic idle_inputs();
        bus.a_valid    = 1'b0;
        bus.a_addr     = '0;
        bus.a_data     = '0;
        bus.b_valid    = 1'b0;
        bus.b_addr     = '0;
        bus.b_data     = '0;
        bus.pwm_active = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One write from A or B; pwm_cap applies in the capture cycle, pwm_sel in the service cycle
    task automatic single_write(input string tag, input bit use_b, input logic [2:0] addr,
                                input logic [7:0] data, input bit pwm_cap, input bit pwm_sel,
                                input bit exp_commit);
        @(posedge clk);
        #1;
        bus.pwm_active = pwm_cap;
        if (use_b) begin
            bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_data = data;
        end else begin
            bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_data = data;
        end
        @(posedge clk);
        #1;
        bus.a_valid    = 1'b0;
        bus.b_valid    = 1'b0;
        bus.pwm_active = pwm_sel;
        @(negedge clk);
        check({tag, "_wr_en"},   32'(bus.wr_en),   32'(exp_commit));
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), exp_commit ? 32'(addr) : 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), exp_commit ? 32'(data) : 32'd0);
        check({tag, "_ack_err"}, {28'd0, bus.b_err, bus.b_ack, bus.a_err, bus.a_ack},
              32'(1) << (2 * int'(use_b) + (exp_commit ? 0 : 1)));
        check({tag, "_busy"}, 32'(use_b ? bus.b_ready : bus.a_ready), 32'd0);
        @(negedge clk);
        check({tag, "_after"}, {27'd0, bus.wr_en, bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}, 32'd0);
        check({tag, "_ready"}, {30'd0, bus.a_ready, bus.b_ready}, 32'd3);
        bus.pwm_active = 1'b0;
    endtask

    initial begin
        logic [2:0] a_addrs [4];
        logic [2:0] b_addrs [4];
        int ai, bi, got, first, last, item;

        idle_inputs();
        #2;
        check("rst_wr_en",   32'(bus.wr_en),   32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_ack_err", {28'd0, bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}, 32'd0);
        check("rst_ready",   {30'd0, bus.a_ready, bus.b_ready}, 32'd3);
        do_reset();

        single_write("single_a3", 1'b0, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b1);

        // Simultaneous writes right after reset: A wins, B follows
        do_reset();
        @(posedge clk);
        #1;
        bus.a_valid = 1'b1; bus.a_addr = 3'd6; bus.a_data = 8'h0F;
        bus.b_valid = 1'b1; bus.b_addr = 3'd7; bus.b_data = 8'hF0;
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        check("sim_n1_wr", {bus.wr_en, 3'd0, bus.wr_addr, bus.wr_data}, {1'b1, 3'd0, 3'd6, 8'h0F});
        check("sim_n1_ack", {28'd0, bus.a_ack, bus.b_ack, bus.a_err, bus.b_err}, 32'h8);
        check("sim_n1_b_ready", 32'(bus.b_ready), 32'd0);
        @(negedge clk);
        check("sim_n2_wr", {bus.wr_en, 3'd0, bus.wr_addr, bus.wr_data}, {1'b1, 3'd0, 3'd7, 8'hF0});
        check("sim_n2_ack", {28'd0, bus.a_ack, bus.b_ack, bus.a_err, bus.b_err}, 32'h4);
        check("sim_n2_a_ready", 32'(bus.a_ready), 32'd1);
        @(negedge clk);
        check("sim_n3_idle", {30'd0, bus.wr_en, bus.b_ready}, 32'd1);

        // Continuous contention: four writes from each side, held valid until accepted
        a_addrs = '{3'd1, 3'd2, 3'd3, 3'd4};
        b_addrs = '{3'd5, 3'd6, 3'd7, 3'd1};
        ai = 0; bi = 0; got = 0; first = -1; last = -1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            if (bus.a_ready && ai < 4) begin
                bus.a_valid = 1'b1; bus.a_addr = a_addrs[ai]; bus.a_data = 8'(8'h10 + ai); ai++;
            end else begin
                bus.a_valid = 1'b0;
            end
            if (bus.b_ready && bi < 4) begin
                bus.b_valid = 1'b1; bus.b_addr = b_addrs[bi]; bus.b_data = 8'(8'h20 + bi); bi++;
            end else begin
                bus.b_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.wr_en && got < 8) begin
                if (first < 0) first = c;
                last = c;
                item = got / 2;
                if (got % 2 == 0) begin
                    check("cont_grant_a", {30'd0, bus.b_ack, bus.a_ack}, 32'd1);
                    check("cont_addr", 32'(bus.wr_addr), 32'(a_addrs[item]));
                    check("cont_data", 32'(bus.wr_data), 32'(8'h10 + item));
                end else begin
                    check("cont_grant_b", {30'd0, bus.b_ack, bus.a_ack}, 32'd2);
                    check("cont_addr", 32'(bus.wr_addr), 32'(b_addrs[item]));
                    check("cont_data", 32'(bus.wr_data), 32'(8'h20 + item));
                end
                got++;
            end else if (bus.wr_en) begin
                got++;
            end
        end
        check("cont_count", 32'(got), 32'd8);
        check("cont_span", 32'(last - first), 32'd7);
        idle_inputs();

        // Write-protect rules and lock window edges
        single_write("prot_id",      1'b0, 3'd0, 8'h11, 1'b0, 1'b0, 1'b0);
        single_write("prot_lock4",   1'b1, 3'd4, 8'h22, 1'b1, 1'b1, 1'b0);
        single_write("prot_ctrl1",   1'b0, 3'd1, 8'h33, 1'b1, 1'b1, 1'b1);
        single_write("prot_io7",     1'b1, 3'd7, 8'h44, 1'b1, 1'b1, 1'b1);
        single_write("prot_lock5",   1'b0, 3'd5, 8'h55, 1'b1, 1'b1, 1'b0);
        single_write("prot_io6",     1'b1, 3'd6, 8'h66, 1'b1, 1'b1, 1'b1);
        single_write("prot_free5",   1'b1, 3'd5, 8'h77, 1'b0, 1'b0, 1'b1);
        single_write("prot_late2",   1'b0, 3'd2, 8'h88, 1'b0, 1'b1, 1'b0);
        single_write("prot_early2",  1'b1, 3'd2, 8'h99, 1'b1, 1'b0, 1'b1);

        // Reset while both slots hold pending writes
        @(posedge clk);
        #1;
        bus.a_valid = 1'b1; bus.a_addr = 3'd3; bus.a_data = 8'h33;
        bus.b_valid = 1'b1; bus.b_addr = 3'd4; bus.b_data = 8'h44;
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #1;
        check("rmid_pre_wr_en", 32'(bus.wr_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rmid_wr", {bus.wr_en, 3'd0, bus.wr_addr, bus.wr_data}, 32'd0);
        check("rmid_ack_err", {28'd0, bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}, 32'd0);
        check("rmid_ready", {30'd0, bus.a_ready, bus.b_ready}, 32'd3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rmid_quiet", {27'd0, bus.wr_en, bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
